btb_assoc: RTL and testbench

//  Set-associative Branch Target Buffer; successor of the direct-mapped BTB in the fetch stage.

---
 rtl/btb_assoc_if.sv | 41 ++++
 rtl/btb_assoc.sv | 168 ++++++++++++++++
 tb/tb_btb_assoc.sv | 278 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/btb_assoc_if.sv
// Types and port bundle for btb_assoc: lookup in, hit/target/way out, one resolution per cycle.
// No backpressure: the BTB accepts every resolution presented with valid_i.
package btb_assoc_pkg;
  localparam int XLEN   = 32;
  localparam int OFFSET = 2;

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] target;
  } resolution_t;
endpackage

interface btb_assoc_if #(
  parameter int WAYS = 4
);
  import btb_assoc_pkg::*;

  localparam int WAY_BITS = (WAYS > 1) ? $clog2(WAYS) : 1;

  logic                   flush_i;
  logic [XLEN-1:0]        pc_i;
  logic                   rd_en_i;
  logic                   valid_i;
  logic                   del_entry_i;
  resolution_t            res_i;
  logic                   hit_o;
  logic [XLEN-OFFSET-1:0] target_o;
  logic [WAY_BITS-1:0]    hit_way_o;
  logic [31:0]            hit_cnt_o;
  logic [31:0]            evict_cnt_o;

  modport master (
    output flush_i, pc_i, rd_en_i, valid_i, del_entry_i, res_i,
    input  hit_o, target_o, hit_way_o, hit_cnt_o, evict_cnt_o
  );

  modport slave (
    input  flush_i, pc_i, rd_en_i, valid_i, del_entry_i, res_i,
    output hit_o, target_o, hit_way_o, hit_cnt_o, evict_cnt_o
  );
endinterface

// File: rtl/btb_assoc.sv
// Set-associative BTB, round-robin replacement per set; 0-cycle lookup, writes land next cycle.
// No backpressure; BTB_STATS_EN adds saturating hit/eviction counters (tied to 0 otherwise).
module btb_assoc
  import btb_assoc_pkg::*;
#(
  parameter int SETS = 64,
  parameter int WAYS = 4
) (
  input  logic        clk_i,
  input  logic        rst_n_i,
  btb_assoc_if.slave  bus
);

  localparam int SET_BITS = $clog2(SETS);
  localparam int WAY_BITS = (WAYS > 1) ? $clog2(WAYS) : 1;
  localparam int TAG_W    = XLEN - OFFSET - SET_BITS;
  localparam int TGT_W    = XLEN - OFFSET;

  logic [WAYS-1:0]     valid_q [SETS];
  logic [TAG_W-1:0]    tag_q   [SETS][WAYS];
  logic [TGT_W-1:0]    tgt_q   [SETS][WAYS];
  logic [WAY_BITS-1:0] rr_q    [SETS];

  logic [SET_BITS-1:0] rd_set;
  logic [TAG_W-1:0]    rd_tag;
  logic                rd_hit;
  logic [WAY_BITS-1:0] rd_way;
  logic [TGT_W-1:0]    rd_tgt;

  assign rd_set = bus.pc_i[SET_BITS+OFFSET-1:OFFSET];
  assign rd_tag = bus.pc_i[XLEN-1:SET_BITS+OFFSET];

  // Scanning from the top way down lets the lowest matching way win.
  always_comb begin
    rd_hit = 1'b0;
    rd_way = '0;
    rd_tgt = '0;
    for (int w = WAYS - 1; w >= 0; w--) begin
      if (valid_q[rd_set][w] && (tag_q[rd_set][w] == rd_tag)) begin
        rd_hit = 1'b1;
        rd_way = WAY_BITS'(w);
        rd_tgt = tgt_q[rd_set][w];
      end
    end
  end

  assign bus.hit_o     = rd_hit;
  assign bus.target_o  = rd_tgt;
  assign bus.hit_way_o = rd_way;

  logic [SET_BITS-1:0] wr_set;
  logic [TAG_W-1:0]    wr_tag;
  logic [TGT_W-1:0]    wr_tgt;
  logic                wr_en;
  logic                wr_match;
  logic [WAY_BITS-1:0] wr_match_way;
  logic                wr_has_free;
  logic [WAY_BITS-1:0] wr_free_way;
  logic [WAY_BITS-1:0] wr_victim;
  logic                wr_evict;
  logic [WAY_BITS-1:0] rr_next;

  assign wr_set = bus.res_i.pc[SET_BITS+OFFSET-1:OFFSET];
  assign wr_tag = bus.res_i.pc[XLEN-1:SET_BITS+OFFSET];
  assign wr_tgt = bus.res_i.target[XLEN-1:OFFSET];
  assign wr_en  = bus.valid_i && !bus.flush_i;

  always_comb begin
    wr_match     = 1'b0;
    wr_match_way = '0;
    wr_has_free  = 1'b0;
    wr_free_way  = '0;
    for (int w = WAYS - 1; w >= 0; w--) begin
      if (valid_q[wr_set][w] && (tag_q[wr_set][w] == wr_tag)) begin
        wr_match     = 1'b1;
        wr_match_way = WAY_BITS'(w);
      end
      if (!valid_q[wr_set][w]) begin
        wr_has_free = 1'b1;
        wr_free_way = WAY_BITS'(w);
      end
    end
  end

  // Only a full set consults or advances the round-robin pointer.
  always_comb begin
    wr_evict  = wr_en && !bus.del_entry_i && !wr_match && !wr_has_free;
    rr_next   = (rr_q[wr_set] == WAY_BITS'(WAYS - 1)) ? '0 : rr_q[wr_set] + 1'b1;
    wr_victim = rr_q[wr_set];
    if (wr_match) begin
      wr_victim = wr_match_way;
    end else if (wr_has_free) begin
      wr_victim = wr_free_way;
    end
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      for (int s = 0; s < SETS; s++) begin
        valid_q[s] <= '0;
        rr_q[s]    <= '0;
        for (int w = 0; w < WAYS; w++) begin
          tag_q[s][w] <= '0;
          tgt_q[s][w] <= '0;
        end
      end
    end else if (bus.flush_i) begin
      for (int s = 0; s < SETS; s++) begin
        valid_q[s] <= '0;
        rr_q[s]    <= '0;
        for (int w = 0; w < WAYS; w++) begin
          tag_q[s][w] <= '0;
          tgt_q[s][w] <= '0;
        end
      end
    end else if (wr_en) begin
      if (bus.del_entry_i) begin
        if (wr_match) begin
          valid_q[wr_set][wr_match_way] <= 1'b0;
          tag_q[wr_set][wr_match_way]   <= '0;
          tgt_q[wr_set][wr_match_way]   <= '0;
        end
      end else begin
        valid_q[wr_set][wr_victim] <= 1'b1;
        tag_q[wr_set][wr_victim]   <= wr_tag;
        tgt_q[wr_set][wr_victim]   <= wr_tgt;
        if (wr_evict) begin
          rr_q[wr_set] <= rr_next;
        end
      end
    end
  end

`ifdef BTB_STATS_EN
  logic [31:0] hit_cnt_q;
  logic [31:0] evict_cnt_q;

  // Flush leaves the counters alone; only reset clears them.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      hit_cnt_q   <= '0;
      evict_cnt_q <= '0;
    end else begin
      if (bus.rd_en_i && rd_hit && (hit_cnt_q != 32'hFFFF_FFFF)) begin
        hit_cnt_q <= hit_cnt_q + 32'd1;
      end
      if (wr_evict && (evict_cnt_q != 32'hFFFF_FFFF)) begin
        evict_cnt_q <= evict_cnt_q + 32'd1;
      end
    end
  end

  assign bus.hit_cnt_o   = hit_cnt_q;
  assign bus.evict_cnt_o = evict_cnt_q;

  logic unused_bits;
  assign unused_bits = ^{bus.pc_i[OFFSET-1:0], bus.res_i.pc[OFFSET-1:0],
                         bus.res_i.target[OFFSET-1:0]};
`else
  assign bus.hit_cnt_o   = 32'h0;
  assign bus.evict_cnt_o = 32'h0;

  logic unused_bits;
  assign unused_bits = ^{bus.pc_i[OFFSET-1:0], bus.res_i.pc[OFFSET-1:0],
                         bus.res_i.target[OFFSET-1:0], bus.rd_en_i};
`endif

endmodule

// File: tb/tb_btb_assoc.sv
// Bench for btb_assoc: directed scenarios with literal expectations plus randomized traffic
// checked every cycle against a table-of-entries model of the BTB.
module tb_btb_assoc;
  import btb_assoc_pkg::*;

  localparam int SETS = 64;
  localparam int WAYS = 4;
`ifdef BTB_STATS_EN
  localparam bit STATS = 1'b1;
`else
  localparam bit STATS = 1'b0;
`endif

  logic clk_i   = 1'b0;
  logic rst_n_i = 1'b0;

  btb_assoc_if #(.WAYS(WAYS)) bus ();

  btb_assoc #(.SETS(SETS), .WAYS(WAYS)) dut (
    .clk_i   (clk_i),
    .rst_n_i (rst_n_i),
    .bus     (bus.slave)
  );

  always #5 clk_i = ~clk_i;

  int checks = 0;
  int fails  = 0;

  function automatic void check(string nm, logic [63:0] act, logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", nm, act, exp, $time);
    end
  endfunction

  // Model: each set is a small table of {valid, pc-above-index, target/4} plus a victim pointer.
  bit          m_valid [SETS][WAYS];
  int unsigned m_tag   [SETS][WAYS];
  int unsigned m_tgt   [SETS][WAYS];
  int          m_rr    [SETS];
  longint unsigned m_hits;
  longint unsigned m_evicts;

  function automatic int set_of(int unsigned pc);
    return int'((pc / 4) % SETS);
  endfunction

  function automatic int unsigned tag_of(int unsigned pc);
    return pc / (4 * SETS);
  endfunction

  function automatic void m_flush();
    for (int s = 0; s < SETS; s++) begin
      m_rr[s] = 0;
      for (int w = 0; w < WAYS; w++) begin
        m_valid[s][w] = 1'b0;
        m_tag[s][w]   = 0;
        m_tgt[s][w]   = 0;
      end
    end
  endfunction

  function automatic void m_reset();
    m_flush();
    m_hits   = 0;
    m_evicts = 0;
  endfunction

  function automatic void m_lookup(input int unsigned pc, output bit hit,
                                   output int unsigned tgt, output int way);
    int s;
    s   = set_of(pc);
    hit = 1'b0;
    tgt = 0;
    way = 0;
    for (int w = 0; w < WAYS; w++) begin
      if (!hit && m_valid[s][w] && m_tag[s][w] == tag_of(pc)) begin
        hit = 1'b1;
        tgt = m_tgt[s][w];
        way = w;
      end
    end
  endfunction

  function automatic void m_step();
    bit h;
    int unsigned tg;
    int wy;
    int s;
    int fr;
    int unsigned rpc;
    rpc = bus.res_i.pc;
    m_lookup(bus.pc_i, h, tg, wy);
    if (bus.rd_en_i && h && m_hits < 64'hFFFF_FFFF) m_hits++;
    if (bus.flush_i) begin
      m_flush();
    end else if (bus.valid_i) begin
      s = set_of(rpc);
      m_lookup(rpc, h, tg, wy);
      if (bus.del_entry_i) begin
        if (h) m_valid[s][wy] = 1'b0;
      end else if (h) begin
        m_tgt[s][wy] = bus.res_i.target / 4;
      end else begin
        fr = -1;
        for (int w = WAYS - 1; w >= 0; w--) if (!m_valid[s][w]) fr = w;
        if (fr < 0) begin
          fr      = m_rr[s];
          m_rr[s] = (m_rr[s] + 1) % WAYS;
          if (m_evicts < 64'hFFFF_FFFF) m_evicts++;
        end
        m_valid[s][fr] = 1'b1;
        m_tag[s][fr]   = tag_of(rpc);
        m_tgt[s][fr]   = bus.res_i.target / 4;
      end
    end
  endfunction

  always @(posedge clk_i) if (rst_n_i) m_step();

  always @(negedge clk_i) begin : cmp
    bit h;
    int unsigned tg;
    int wy;
    if (rst_n_i) begin
      m_lookup(bus.pc_i, h, tg, wy);
      check("hit_o", 64'(bus.hit_o), 64'(h));
      check("target_o", 64'(bus.target_o), 64'(tg));
      check("hit_way_o", 64'(bus.hit_way_o), 64'(wy));
      check("hit_cnt_o", 64'(bus.hit_cnt_o), STATS ? m_hits : 64'd0);
      check("evict_cnt_o", 64'(bus.evict_cnt_o), STATS ? m_evicts : 64'd0);
    end
  end

  task automatic cyc();
    @(posedge clk_i);
    #1;
  endtask

  task automatic wr(input logic [31:0] pc, input logic [31:0] tgt, input bit del = 1'b0);
    bus.res_i.pc     = pc;
    bus.res_i.target = tgt;
    bus.valid_i      = 1'b1;
    bus.del_entry_i  = del;
    cyc();
    bus.valid_i     = 1'b0;
    bus.del_entry_i = 1'b0;
  endtask

  task automatic look(string nm, input logic [31:0] pc, input bit eh,
                      input logic [29:0] et, input int ew);
    bus.pc_i = pc;
    #1;
    check({nm, "_hit"}, 64'(bus.hit_o), 64'(eh));
    check({nm, "_tgt"}, 64'(bus.target_o), 64'(et));
    check({nm, "_way"}, 64'(bus.hit_way_o), 64'(ew));
  endtask

  task automatic check_all_zero(string nm);
    check({nm, "_hit"}, 64'(bus.hit_o), 64'd0);
    check({nm, "_tgt"}, 64'(bus.target_o), 64'd0);
    check({nm, "_way"}, 64'(bus.hit_way_o), 64'd0);
    check({nm, "_hcnt"}, 64'(bus.hit_cnt_o), 64'd0);
    check({nm, "_ecnt"}, 64'(bus.evict_cnt_o), 64'd0);
  endtask

  function automatic logic [31:0] rand_pc();
    return (32'($urandom_range(0, 5)) << 8) | (32'($urandom_range(0, 3)) << 2)
           | 32'($urandom_range(0, 3));
  endfunction

  initial begin
    bus.flush_i     = 1'b0;
    bus.pc_i        = 32'h100;
    bus.rd_en_i     = 1'b0;
    bus.valid_i     = 1'b0;
    bus.del_entry_i = 1'b0;
    bus.res_i       = '0;
    m_reset();
    #2;
    check_all_zero("reset");
    cyc();
    rst_n_i = 1'b1;

    // Scenario 1: first allocation, visible the cycle after the write.
    look("t1_pre", 32'h100, 1'b0, 30'h0, 0);
    wr(32'h100, 32'h200);
    look("t1", 32'h100, 1'b1, 30'h80, 0);
    bus.rd_en_i = 1'b1;
    cyc();
    bus.rd_en_i = 1'b0;

    // Scenario 2: fill set 0, fifth tag evicts way 0.
    wr(32'h200, 32'h1000);
    wr(32'h300, 32'h3000);
    wr(32'h400, 32'h4000);
    wr(32'h500, 32'h5000);
    look("t2_old", 32'h100, 1'b0, 30'h0, 0);
    look("t2_new", 32'h500, 1'b1, 30'h1400, 0);
    check("t2_evict", 64'(bus.evict_cnt_o), STATS ? 64'd1 : 64'd0);

    // Scenario 3: rewriting a present tag updates in place.
    wr(32'h200, 32'h900);
    look("t3", 32'h200, 1'b1, 30'h240, 1);
    check("t3_evict", 64'(bus.evict_cnt_o), STATS ? 64'd1 : 64'd0);

    // Scenario 4: delete frees way 2, which the next miss takes instead of rr.
    wr(32'h300, 32'h0, 1'b1);
    look("t4_del", 32'h300, 1'b0, 30'h0, 0);
    wr(32'h600, 32'h6000);
    look("t4_fill", 32'h600, 1'b1, 30'h1800, 2);

    // Scenario 5: flush beats a same-cycle write; counters survive; rr restarts at 0.
    bus.flush_i = 1'b1;
    wr(32'h700, 32'h7000);
    bus.flush_i = 1'b0;
    look("t5_drop", 32'h700, 1'b0, 30'h0, 0);
    look("t5_gone", 32'h500, 1'b0, 30'h0, 0);
    check("t5_hcnt", 64'(bus.hit_cnt_o), STATS ? 64'd1 : 64'd0);
    wr(32'h100, 32'h10);
    wr(32'h200, 32'h20);
    wr(32'h300, 32'h30);
    wr(32'h400, 32'h40);
    wr(32'h500, 32'h50);
    look("t5_rr", 32'h500, 1'b1, 30'h14, 0);
    look("t5_rr_old", 32'h100, 1'b0, 30'h0, 0);

    // Scenario 6: same-cycle read sees pre-write state; async reset clears at once.
    bus.pc_i         = 32'h104;
    bus.res_i.pc     = 32'h104;
    bus.res_i.target = 32'h2000;
    bus.valid_i      = 1'b1;
    #1;
    check("t6_same", 64'(bus.hit_o), 64'd0);
    cyc();
    bus.valid_i = 1'b0;
    look("t6_next", 32'h104, 1'b1, 30'h800, 0);
    #1;
    rst_n_i = 1'b0;
    m_reset();
    #1;
    check_all_zero("t6_arst");
    cyc();
    rst_n_i = 1'b1;
    look("t6_after", 32'h104, 1'b0, 30'h0, 0);

    // Randomized traffic over a few crowded sets.
    for (int i = 0; i < 3000; i++) begin
      bus.pc_i         = rand_pc();
      bus.rd_en_i      = 1'($urandom_range(0, 1));
      bus.valid_i      = ($urandom_range(0, 3) != 0);
      bus.del_entry_i  = ($urandom_range(0, 9) == 0);
      bus.flush_i      = ($urandom_range(0, 99) == 0);
      bus.res_i.pc     = rand_pc();
      bus.res_i.target = $urandom();
      if (i == 1500) begin
        #2;
        rst_n_i = 1'b0;
        m_reset();
        #1;
        check_all_zero("rand_arst");
        cyc();
        rst_n_i = 1'b1;
      end else begin
        cyc();
      end
    end

    bus.valid_i = 1'b0;
    bus.flush_i = 1'b0;
    cyc();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
